agc_timepulse_gen: RTL and testbench

Parametrised successor to the A2 timer module. It divides the master CLOCK into a configurable number of clock phases per timepulse and timepulses per memory cycle, and produces one-hot timepulses, phase strobes, odd/even indicators and GOJAM restart. It also provides monitor stop, single-step and standby hold. It sits between the oscillator and the control-pulse/sequence logic, as the A2 timer does today, and adds run-time stepping and GOJAM stretching.

---
 rtl/agc_timing_pkg.sv | 30 +++
 rtl/agc_tp_ring.sv | 56 +++++
 rtl/agc_timepulse_gen.sv | 150 +++++++++++++++
 tb/tb_agc_timepulse_gen.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/agc_timing_pkg.sv
// Shared timing definitions for the AGC timepulse generator: index widths,
// phase-strobe positions and default geometry.
package agc_timing_pkg;

  localparam int unsigned DEF_NT        = 12;
  localparam int unsigned DEF_PHASES    = 4;
  localparam int unsigned DEF_GOJAM_LEN = 8;

  // Width of a counter holding 0..n-1, never less than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
  endfunction

  function automatic int unsigned phs2_idx(input int unsigned phases);
    return phases / 32'd2 - 32'd1;
  endfunction

  function automatic int unsigned phs4_idx(input int unsigned phases);
    return phases - 32'd1;
  endfunction

  localparam int unsigned PH_W     = idx_w(DEF_PHASES);
  localparam int unsigned TP_W     = idx_w(DEF_NT);
  localparam int unsigned PHS2_IDX = phs2_idx(DEF_PHASES);
  localparam int unsigned PHS4_IDX = phs4_idx(DEF_PHASES);

  typedef logic [PH_W-1:0] ph_t;
  typedef logic [TP_W-1:0] tp_t;

endpackage

// File: rtl/agc_tp_ring.sv
// Phase / timepulse counter pair with hold and force-load. Exposes the
// next-state values so the top can register decoded outputs alongside.
module agc_tp_ring
  import agc_timing_pkg::*;
#(
  parameter int unsigned NT     = DEF_NT,
  parameter int unsigned PHASES = DEF_PHASES,
  localparam int unsigned PW    = idx_w(PHASES),
  localparam int unsigned TW    = idx_w(NT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold,
  input  logic          load,
  input  logic [PW-1:0] load_ph,
  input  logic [TW-1:0] load_tp,
  output logic [PW-1:0] ph_nxt_c,
  output logic [TW-1:0] tp_nxt_c,
  output logic          cyc_end_c
);

  logic [PW-1:0] ph_q, ph_d;
  logic [TW-1:0] tp_q, tp_d;
  logic          ph_wrap;

  always_comb begin
    ph_wrap   = (ph_q == PW'(PHASES - 1));
    cyc_end_c = ph_wrap && (tp_q == TW'(NT - 1));
    ph_d      = ph_q;
    tp_d      = tp_q;
    if (load) begin
      ph_d = load_ph;
      tp_d = load_tp;
    end else if (!hold) begin
      if (ph_wrap) begin
        ph_d = '0;
        tp_d = (tp_q == TW'(NT - 1)) ? '0 : tp_q + TW'(1);
      end else begin
        ph_d = ph_q + PW'(1);
      end
    end
    ph_nxt_c = ph_d;
    tp_nxt_c = tp_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph_q <= '0;
      tp_q <= TW'(NT - 1);
    end else begin
      ph_q <= ph_d;
      tp_q <= tp_d;
    end
  end

endmodule

// File: rtl/agc_timepulse_gen.sv
// AGC timepulse generator: one-hot timepulses, phase strobes, GOJAM restart
// stretching, monitor stop / single-step and standby hold.
module agc_timepulse_gen
  import agc_timing_pkg::*;
#(
  parameter int unsigned NT        = DEF_NT,
  parameter int unsigned PHASES    = DEF_PHASES,
  parameter int unsigned GOJAM_LEN = DEF_GOJAM_LEN
) (
  input  logic          CLOCK,
  input  logic          rst,
  input  logic          STRT1,
  input  logic          STRT2,
  input  logic          MSTP,
  input  logic          MSTRTP,
  input  logic          SBY,
  output logic [NT-1:0] T,
  output logic [NT-1:0] T_,
  output logic          PHS2,
  output logic          PHS4,
  output logic          CT,
  output logic          EVNSET,
  output logic          ODDSET_,
  output logic          GOJAM,
  output logic          GOJAM_,
  output logic          STOP
);

  localparam int unsigned PHW     = idx_w(PHASES);
  localparam int unsigned TPW     = idx_w(NT);
  localparam int unsigned GJW     = idx_w(GOJAM_LEN + 1);
  localparam int unsigned PHS2_AT = phs2_idx(PHASES);
  localparam int unsigned PHS4_AT = phs4_idx(PHASES);
  localparam logic        EVN_RST = ((NT % 2) == 0);

  logic           stopped_q, stopped_d;
  logic           step_q, step_d;
  logic           full_q, full_d;
  logic [GJW-1:0] gj_q, gj_d;
  logic           mstrtp_q;

  logic [NT-1:0]  t_q, t_d;
  logic           ct_q, ct_d, phs2_q, phs2_d, phs4_q, phs4_d;
  logic           evn_q, evn_d, gojam_q, gojam_d, stop_q, stop_d;

  logic           hold, load;
  logic [TPW-1:0] load_tp;
  logic [PHW-1:0] ph_nxt_c;
  logic [TPW-1:0] tp_nxt_c;
  logic           cyc_end_c;
  logic           strt;

  assign strt = STRT1 | STRT2;

  agc_tp_ring #(.NT(NT), .PHASES(PHASES)) u_ring (
    .clk       (CLOCK),
    .rst       (rst),
    .hold      (hold),
    .load      (load),
    .load_ph   ('0),
    .load_tp   (load_tp),
    .ph_nxt_c  (ph_nxt_c),
    .tp_nxt_c  (tp_nxt_c),
    .cyc_end_c (cyc_end_c)
  );

  // Sequencer control plus decode of the next state into output registers.
  always_comb begin
    stopped_d = stopped_q;
    step_d    = step_q;
    full_d    = full_q;
    gj_d      = gj_q;
    hold      = stopped_q;
    load      = 1'b0;
    load_tp   = '0;

    if (strt) begin
      gj_d      = GJW'(GOJAM_LEN);
      full_d    = 1'b0;
      stopped_d = 1'b0;
      step_d    = 1'b0;
      hold      = 1'b0;
      load      = 1'b1;
      load_tp   = TPW'(NT - 1);
    end else if (stopped_q) begin
      if (MSTRTP && !mstrtp_q && !SBY) begin
        stopped_d = 1'b0;
        step_d    = 1'b1;
      end else if (!MSTP && !SBY) begin
        stopped_d = 1'b0;
      end
    end else if (cyc_end_c) begin
      // The partial lead-in cycle after a restart does not count toward GOJAM.
      step_d = 1'b0;
      full_d = 1'b1;
      if (full_q && (gj_q != '0)) gj_d = gj_q - GJW'(1);
      if ((gj_q == '0) && (MSTP || SBY)) stopped_d = 1'b1;
    end

    t_d     = NT'(1) << tp_nxt_c;
    ct_d    = !stopped_d && (ph_nxt_c < PHW'(PHASES / 2));
    phs2_d  = !stopped_d && (ph_nxt_c == PHW'(PHS2_AT));
    phs4_d  = !stopped_d && (ph_nxt_c == PHW'(PHS4_AT));
    evn_d   = tp_nxt_c[0];
    gojam_d = (gj_d != '0);
    stop_d  = stopped_d;
  end

  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      stopped_q <= 1'b0;
      step_q    <= 1'b0;
      full_q    <= 1'b0;
      gj_q      <= GJW'(GOJAM_LEN);
      mstrtp_q  <= 1'b0;
      t_q       <= {1'b1, {(NT - 1){1'b0}}};
      ct_q      <= 1'b1;
      phs2_q    <= 1'b0;
      phs4_q    <= 1'b0;
      evn_q     <= EVN_RST;
      gojam_q   <= 1'b1;
      stop_q    <= 1'b0;
    end else begin
      stopped_q <= stopped_d;
      step_q    <= step_d;
      full_q    <= full_d;
      gj_q      <= gj_d;
      mstrtp_q  <= MSTRTP;
      t_q       <= t_d;
      ct_q      <= ct_d;
      phs2_q    <= phs2_d;
      phs4_q    <= phs4_d;
      evn_q     <= evn_d;
      gojam_q   <= gojam_d;
      stop_q    <= stop_d;
    end
  end

  assign T       = t_q;
  assign T_      = ~t_q;
  assign PHS2    = phs2_q;
  assign PHS4    = phs4_q;
  assign CT      = ct_q;
  assign EVNSET  = evn_q;
  assign ODDSET_ = evn_q;
  assign GOJAM   = gojam_q;
  assign GOJAM_  = ~gojam_q;
  assign STOP    = stop_q;

endmodule

// File: tb/tb_agc_timepulse_gen.sv
// Directed bench for agc_timepulse_gen: default geometry instance plus an
// NT=8 / PHASES=6 instance for the restart scenario.
module tb_agc_timepulse_gen;

  logic CLOCK = 1'b0;
  logic rst   = 1'b1;
  logic strt1 = 1'b0, strt2 = 1'b0, mstp = 1'b0, mstrtp = 1'b0, sby = 1'b0;
  logic [11:0] t, t_n;
  logic phs2, phs4, ct, evnset, oddset_n, gojam, gojam_n, stop;

  logic strt1_b = 1'b0, strt2_b = 1'b0, mstp_b = 1'b1, mstrtp_b = 1'b0, sby_b = 1'b0;
  logic [7:0] t_b, t_nb;
  logic phs2_b, phs4_b, ct_b, evnset_b, oddset_nb, gojam_b, gojam_nb, stop_b;

  int checks = 0;
  int failures = 0;
  int g = 0;

  always #5 CLOCK = ~CLOCK;

  agc_timepulse_gen dut (
    .CLOCK(CLOCK), .rst(rst), .STRT1(strt1), .STRT2(strt2), .MSTP(mstp),
    .MSTRTP(mstrtp), .SBY(sby), .T(t), .T_(t_n), .PHS2(phs2), .PHS4(phs4),
    .CT(ct), .EVNSET(evnset), .ODDSET_(oddset_n), .GOJAM(gojam),
    .GOJAM_(gojam_n), .STOP(stop)
  );

  agc_timepulse_gen #(.NT(8), .PHASES(6), .GOJAM_LEN(8)) dut_b (
    .CLOCK(CLOCK), .rst(rst), .STRT1(strt1_b), .STRT2(strt2_b), .MSTP(mstp_b),
    .MSTRTP(mstrtp_b), .SBY(sby_b), .T(t_b), .T_(t_nb), .PHS2(phs2_b),
    .PHS4(phs4_b), .CT(ct_b), .EVNSET(evnset_b), .ODDSET_(oddset_nb),
    .GOJAM(gojam_b), .GOJAM_(gojam_nb), .STOP(stop_b)
  );

  task automatic test_reset();
    repeat (3) @(negedge CLOCK);
    checks++;
    if ({t, t_n} !== {12'h800, 12'h7ff}) begin
      failures++; $display("FAIL reset_t: got %h/%h expected 800/7ff", t, t_n);
    end
    checks++;
    if ({gojam, gojam_n, stop} !== 3'b100) begin
      failures++; $display("FAIL reset_gojam_stop: got %b expected 100", {gojam, gojam_n, stop});
    end
    checks++;
    if ({ct, phs2, phs4, evnset, oddset_n} !== 5'b10011) begin
      failures++; $display("FAIL reset_strobes: got %b expected 10011", {ct, phs2, phs4, evnset, oddset_n});
    end
    checks++;
    if ({t_b, gojam_b, evnset_b} !== {8'h80, 1'b1, 1'b1}) begin
      failures++; $display("FAIL reset_b: got %h %b %b expected 80 1 1", t_b, gojam_b, evnset_b);
    end
    rst = 1'b0;
    g = 44;
  endtask

  // Free run from T12 phase 0 after reset; k counts edges since release.
  task automatic test_free_run();
    int tp, ph;
    for (int k = 1; k <= 100; k++) begin
      @(negedge CLOCK);
      g = (g + 1) % 48; tp = g / 4; ph = g % 4;
      checks++;
      if (t !== (12'h1 << tp)) begin
        failures++; $display("FAIL run_t k=%0d: got %h expected %h", k, t, 12'h1 << tp);
      end
      checks++;
      if ({ct, phs2, phs4, evnset, stop} !== {ph < 2, ph == 1, ph == 3, tp % 2 == 1, 1'b0}) begin
        failures++; $display("FAIL run_strobes k=%0d: got %b expected %b", k,
          {ct, phs2, phs4, evnset, stop}, {ph < 2, ph == 1, ph == 3, tp % 2 == 1, 1'b0});
      end
    end
  endtask

  // First cycle end is edge 4; GOJAM must fall 384 CLOCKs later, at edge 388.
  task automatic test_gojam_release();
    logic eg;
    for (int k = 101; k <= 400; k++) begin
      @(negedge CLOCK);
      g = (g + 1) % 48;
      eg = (k < 388);
      checks++;
      if ({gojam, gojam_n} !== {eg, ~eg}) begin
        failures++; $display("FAIL gojam k=%0d: got %b expected %b", k, {gojam, gojam_n}, {eg, ~eg});
      end
      checks++;
      if (t !== (12'h1 << (g / 4))) begin
        failures++; $display("FAIL gojam_t k=%0d: got %h expected %h", k, t, 12'h1 << (g / 4));
      end
    end
  endtask

  task automatic test_mstp_stop();
    int guard = 0;
    while (g / 4 != 4 && guard < 60) begin
      @(negedge CLOCK); g = (g + 1) % 48; guard++;
    end
    mstp = 1'b1;
    do begin
      @(negedge CLOCK); g = (g + 1) % 48;
      if (g != 0) begin
        checks++;
        if (stop !== 1'b0 || t !== (12'h1 << (g / 4))) begin
          failures++; $display("FAIL mstp_pre g=%0d: got stop=%b t=%h expected 0 %h", g, stop, t, 12'h1 << (g / 4));
        end
      end
    end while (g != 0);
    checks++;
    if ({stop, t} !== {1'b1, 12'h001}) begin
      failures++; $display("FAIL mstp_stop: got %b %h expected 1 001", stop, t);
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge CLOCK);
      checks++;
      if ({stop, t, ct, phs2, phs4} !== {1'b1, 12'h001, 3'b000}) begin
        failures++; $display("FAIL mstp_hold k=%0d: got %b %h %b expected 1 001 000", k, stop, t, {ct, phs2, phs4});
      end
    end
  endtask

  task automatic test_single_step();
    int low_cnt, p4_cnt;
    for (int p = 0; p < 3; p++) begin
      low_cnt = 0; p4_cnt = 0;
      mstrtp = 1'b1;
      for (int k = 1; k <= 100; k++) begin
        @(negedge CLOCK);
        if (k == 5) mstrtp = 1'b0;
        if (!stop) low_cnt++;
        if (phs4) p4_cnt++;
        if (k == 1) begin
          checks++;
          if ({stop, t, ct} !== {1'b0, 12'h001, 1'b1}) begin
            failures++; $display("FAIL step_start p=%0d: got %b %h %b expected 0 001 1", p, stop, t, ct);
          end
        end
        if (k == 48) begin
          checks++;
          if ({stop, t, phs4} !== {1'b0, 12'h800, 1'b1}) begin
            failures++; $display("FAIL step_last p=%0d: got %b %h %b expected 0 800 1", p, stop, t, phs4);
          end
        end
        if (k == 49) begin
          checks++;
          if ({stop, t} !== {1'b1, 12'h001}) begin
            failures++; $display("FAIL step_restop p=%0d: got %b %h expected 1 001", p, stop, t);
          end
        end
      end
      checks++;
      if (low_cnt != 48 || p4_cnt != 12) begin
        failures++; $display("FAIL step_count p=%0d: got low=%0d phs4=%0d expected 48 12", p, low_cnt, p4_cnt);
      end
    end
  endtask

  task automatic test_standby();
    int low_cnt = 0;
    logic [2:0] exp_s [4] = '{3'b100, 3'b110, 3'b000, 3'b001};
    sby = 1'b1;
    mstrtp = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge CLOCK);
      if (k == 5) mstrtp = 1'b0;
      if (!stop) low_cnt++;
    end
    checks++;
    if (low_cnt != 0) begin
      failures++; $display("FAIL sby_step: got %0d running clocks expected 0", low_cnt);
    end
    sby = 1'b0;
    mstp = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLOCK);
      checks++;
      if ({stop, t, ct, phs2, phs4} !== {1'b0, 12'h001, exp_s[k]}) begin
        failures++; $display("FAIL resume k=%0d: got %b %h %b expected 0 001 %b", k, stop, t, {ct, phs2, phs4}, exp_s[k]);
      end
    end
  endtask

  task automatic test_strt_while_stopped();
    int guard = 0;
    mstp = 1'b1;
    while (!stop && guard < 60) begin
      @(negedge CLOCK); guard++;
    end
    checks++;
    if (stop !== 1'b1) begin
      failures++; $display("FAIL strt_prestop: got stop=%b expected 1", stop);
    end
    strt1 = 1'b1;
    @(negedge CLOCK);
    strt1 = 1'b0;
    checks++;
    if ({stop, gojam, t, ct} !== {1'b0, 1'b1, 12'h800, 1'b1}) begin
      failures++; $display("FAIL strt_load: got %b %b %h %b expected 0 1 800 1", stop, gojam, t, ct);
    end
    for (int k = 2; k <= 53; k++) begin
      @(negedge CLOCK);
      if (k == 5 || k == 53) begin
        checks++;
        if ({stop, gojam, t} !== {1'b0, 1'b1, 12'h001}) begin
          failures++; $display("FAIL strt_t01 k=%0d: got %b %b %h expected 0 1 001", k, stop, gojam, t);
        end
      end
      if (k == 52) begin
        checks++;
        if ({t, phs4} !== {12'h800, 1'b1}) begin
          failures++; $display("FAIL strt_t12 k=%0d: got %h %b expected 800 1", k, t, phs4);
        end
      end
    end
    mstp = 1'b0;
  endtask

  task automatic test_async_reset();
    @(negedge CLOCK);
    checks++;
    if ({t, phs2} !== {12'h001, 1'b1}) begin
      failures++; $display("FAIL areset_pre: got %h %b expected 001 1", t, phs2);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({t, phs2, ct, gojam, stop} !== {12'h800, 1'b0, 1'b1, 1'b1, 1'b0}) begin
      failures++; $display("FAIL areset: got %h %b%b%b%b expected 800 0110", t, phs2, ct, gojam, stop);
    end
    @(negedge CLOCK);
    rst = 1'b0;
  endtask

  task automatic test_strt_b();
    int guard = 0;
    logic [2:0] s;
    while (!stop_b && guard < 700) begin
      @(negedge CLOCK); guard++;
    end
    checks++;
    if (stop_b !== 1'b1) begin
      failures++; $display("FAIL b_prestop: got stop=%b expected 1", stop_b);
    end
    strt2_b = 1'b1;
    @(negedge CLOCK);
    strt2_b = 1'b0;
    checks++;
    if ({stop_b, gojam_b, t_b, ct_b, evnset_b} !== {1'b0, 1'b1, 8'h80, 1'b1, 1'b1}) begin
      failures++; $display("FAIL b_load: got %b %b %h %b %b expected 0 1 80 1 1", stop_b, gojam_b, t_b, ct_b, evnset_b);
    end
    for (int k = 2; k <= 55; k++) begin
      @(negedge CLOCK);
      s = {ct_b, phs2_b, phs4_b};
      checks++;
      if (stop_b !== 1'b0) begin
        failures++; $display("FAIL b_stop k=%0d: got %b expected 0", k, stop_b);
      end
      if (k == 3 && s !== 3'b110) begin
        failures++; $display("FAIL b_phs2: got %b expected 110", s);
      end
      if (k == 4 && s !== 3'b000) begin
        failures++; $display("FAIL b_ct_low: got %b expected 000", s);
      end
      if (k == 6 && {t_b, s} !== {8'h80, 3'b001}) begin
        failures++; $display("FAIL b_phs4: got %h %b expected 80 001", t_b, s);
      end
      if ((k == 7 || k == 55) && {t_b, evnset_b, s} !== {8'h01, 1'b0, 3'b100}) begin
        failures++; $display("FAIL b_t01 k=%0d: got %h %b %b expected 01 0 100", k, t_b, evnset_b, s);
      end
      if (k == 54 && t_b !== 8'h80) begin
        failures++; $display("FAIL b_t8: got %h expected 80", t_b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_gojam_release();
    test_mstp_stop();
    test_single_step();
    test_standby();
    test_strt_while_stopped();
    test_async_reset();
    test_strt_b();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
